reg_write: RTL
==============

REG_WRITE -- requirements
Module: reg_write

Interface
REQ-001 SHALL have parameter REG_W, default 8, meaning register data width.
REQ-002 SHALL have parameter NREG, default 16, meaning number of registers; address width is 4.
REQ-003 SHALL have parameter DEPTH, default 2, meaning write-buffer entries.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have wr_valid  input  1  write request present.
REQ-006 SHALL have wr_ready  output  1  buffer can accept a request.
REQ-007 SHALL have wr_addr  input  4  destination register.
REQ-008 SHALL have wr_data  input  REG_W  write data.
REQ-009 SHALL have freeze  input  1  hold all commits this cycle.
REQ-010 SHALL have r0 .. r15  output  REG_W each  register contents, matching the read-mux inputs.
REQ-011 SHALL have pending  output  NREG  bit i set while any buffered write targets register i.

Function
REQ-012 SHALL accept a request on a rising edge where wr_valid and wr_ready are both 1, and push {wr_addr, wr_data} at the FIFO tail.
REQ-013 SHALL drive wr_ready = 1 iff the buffer holds fewer than DEPTH entries; wr_ready SHALL NOT depend on same-cycle drain.
REQ-014 SHALL commit the head entry on a rising edge iff the buffer was non-empty before that edge and freeze = 0.
REQ-015 SHALL perform at most one commit per cycle.
REQ-016 SHALL have a minimum latency of one cycle: a request accepted at edge N SHALL be visible on rN outputs after edge N+1 when freeze = 0. There SHALL be no same-edge bypass from wr_data to the array.
REQ-017 SHALL allow push and commit on the same edge; occupancy is then unchanged.
REQ-018 SHALL ignore wr_valid when full; the requester SHALL hold the request, and no data SHALL be dropped or overwritten.
REQ-019 SHALL commit buffered writes in acceptance order; for two entries with the same address, the later one wins.
REQ-020 SHALL keep buffer contents and array contents unchanged while freeze = 1; pushes SHALL continue while not full.
REQ-021 SHALL make all 16 registers writable, including r0, which SHALL NOT be hardwired.
REQ-022 SHALL compute pending combinationally from valid buffer entries; the bit SHALL clear after the commit edge of the last entry targeting that register.
REQ-023 SHALL wrap the head/tail pointers modulo DEPTH; occupancy SHALL be tracked with a counter from 0 to DEPTH.

Reset
REQ-024 SHALL, when rst_n = 0, immediately clear every register to 0, empty the buffer, zero pending, and drive wr_ready = 1.
REQ-025 SHALL discard all buffered writes on a reset asserted mid-operation; no partial commit is allowed.
REQ-026 SHALL accept the first request on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place REG_W, NREG, the address width of 4, DEPTH, and the write-entry struct {addr, data} in a shared package, reg_pkg, which is also used by the read mux and ALU.
REQ-028 SHALL implement the buffer as sub-module wb_fifo (push/pop/full/empty/entry view); reg_write SHALL hold the array, the commit logic and the pending decode.

Verification
REQ-029 SHALL cover this reset scenario: reset, then write addr 3, data 0x5A with freeze = 0 -> r3 = 0x5A one edge after acceptance; pending[3] is high for exactly one cycle.
REQ-030 SHALL cover this full/back-pressure scenario: freeze = 1, push addr 1 = 0x11 and addr 2 = 0x22 -> wr_ready = 0, pending = 0x0006; push addr 4 = 0x44 held; release freeze -> r1, r2, r4 commit on three consecutive edges.
REQ-031 SHALL cover this same-address scenario: freeze = 1, push addr 7 = 0xAA then addr 7 = 0xBB, release -> r7 reads 0xAA for one cycle, then 0xBB; pending[7] clears after the second commit.
REQ-032 SHALL cover this streaming scenario: back-to-back pushes every cycle for 10 cycles (addr i, data 0x10+i) with freeze = 0 -> wr_ready stays 1 and r0..r9 = 0x10..0x19.
REQ-033 SHALL cover this mid-operation reset scenario: two entries buffered, rst_n pulsed low between edges -> all r outputs = 0, pending = 0, wr_ready = 1 immediately, and neither entry is ever committed.
REQ-034 SHALL cover this r0/r15 boundary scenario: write addr 0 = 0xFF and addr 15 = 0x80 -> r0 = 0xFF and r15 = 0x80, with no other register changed.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared register-file parameters and the buffered write entry format,
// used by the write path, the read mux and the ALU.
package reg_pkg;
  localparam int REG_W  = 8;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);
endpackage

// File: rtl/wb_fifo.sv
// Write buffer: DEPTH-entry FIFO with a per-slot view for pending decode.
// Push is ignored while full and pop is ignored while empty; full/empty come from state only.
module wb_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [W-1:0]            i_push_dat,
  input  logic                    i_pop,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [W-1:0]            o_head_dat,
  output logic [DEPTH-1:0][W-1:0] o_ent_dat,
  output logic [DEPTH-1:0]        o_ent_vld
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [CW-1:0]           r_count;
  logic                    w_push;
  logic                    w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_head];
  assign o_ent_dat  = r_mem;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    int off;
    off       = 0;
    o_ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = i - int'(r_head);
      if (off < 0) off = off + DEPTH;
      o_ent_vld[i] = (off < int'(r_count));
    end
  end
endmodule

// File: rtl/reg_write.sv
// Register array write path: requests queue in wb_fifo and commit one per cycle
// unless frozen; wr_ready drops only when the buffer is full.
module reg_write #(
  parameter int REG_W = reg_pkg::REG_W,
  parameter int NREG  = reg_pkg::NREG,
  parameter int DEPTH = reg_pkg::DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [reg_pkg::ADDR_W-1:0] wr_addr,
  input  logic [REG_W-1:0]          wr_data,
  input  logic                      freeze,
  output logic [REG_W-1:0]          r0,
  output logic [REG_W-1:0]          r1,
  output logic [REG_W-1:0]          r2,
  output logic [REG_W-1:0]          r3,
  output logic [REG_W-1:0]          r4,
  output logic [REG_W-1:0]          r5,
  output logic [REG_W-1:0]          r6,
  output logic [REG_W-1:0]          r7,
  output logic [REG_W-1:0]          r8,
  output logic [REG_W-1:0]          r9,
  output logic [REG_W-1:0]          r10,
  output logic [REG_W-1:0]          r11,
  output logic [REG_W-1:0]          r12,
  output logic [REG_W-1:0]          r13,
  output logic [REG_W-1:0]          r14,
  output logic [REG_W-1:0]          r15,
  output logic [NREG-1:0]           pending
);
  import reg_pkg::*;

  logic [REG_W-1:0]              r_regs [NREG];
  wr_entry_t                     w_push_ent;
  wr_entry_t                     w_head;
  logic [ENTRY_W-1:0]            w_head_raw;
  logic [DEPTH-1:0][ENTRY_W-1:0] w_ent_raw;
  logic [DEPTH-1:0]              w_ent_vld;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_commit;

  assign w_push_ent = '{addr: wr_addr, data: wr_data};
  assign w_head     = wr_entry_t'(w_head_raw);
  assign wr_ready   = !w_full;
  assign w_commit   = !w_empty && !freeze;

  wb_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_wb_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (wr_valid),
    .i_push_dat (w_push_ent),
    .i_pop      (!freeze),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head_raw),
    .o_ent_dat  (w_ent_raw),
    .o_ent_vld  (w_ent_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[w_head.addr] <= w_head.data;
    end
  end

  always_comb begin
    wr_entry_t e;
    e       = '0;
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = wr_entry_t'(w_ent_raw[i]);
      if (w_ent_vld[i]) pending[e.addr] = 1'b1;
    end
  end

  assign r0  = r_regs[0];
  assign r1  = r_regs[1];
  assign r2  = r_regs[2];
  assign r3  = r_regs[3];
  assign r4  = r_regs[4];
  assign r5  = r_regs[5];
  assign r6  = r_regs[6];
  assign r7  = r_regs[7];
  assign r8  = r_regs[8];
  assign r9  = r_regs[9];
  assign r10 = r_regs[10];
  assign r11 = r_regs[11];
  assign r12 = r_regs[12];
  assign r13 = r_regs[13];
  assign r14 = r_regs[14];
  assign r15 = r_regs[15];
endmodule
